// File: rtl/spi_slave_mem_if.sv
// SPI pin and status bundle for spi_slave_mem.
// The master modport is the SPI master or bench side, and the slave modport is the memory model.
interface spi_slave_mem_if #(
  parameter int unsigned DATA_W = 8
);
  logic              cpol;
  logic              cpha;
  logic              sck;
  logic              ena;
  logic              din;
  logic              dout;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              cmd_rw;

  modport master (
    output cpol, cpha, sck, ena, din,
    input  dout, rx_data, rx_valid, busy, cmd_rw
  );

  modport slave (
    input  cpol, cpha, sck, ena, din,
    output dout, rx_data, rx_valid, busy, cmd_rw
  );
endinterface

// File: rtl/spi_slave_mem.sv
// SPI slave memory model that supports all four CPOL/CPHA modes.
// The SPI pins are oversampled on clk. A command word is followed by streamed reads or writes.
module spi_slave_mem #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 3,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter bit                MSB_FIRST   = 1'b1,
  parameter logic [DATA_W-1:0] STATUS_WORD = DATA_W'('hA5)
) (
  input logic           clk,
  input logic           rst,
  spi_slave_mem_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

  state_e st_q, st_d;

  logic [SYNC_STAGES-1:0] sck_sync, ena_sync, din_sync;
  logic                   sck_prev, ena_prev;
  logic                   cpol_q, cpha_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      rx_shift_q, tx_shift_q, tx_next_q, rx_data_q;
  logic                   rx_valid_q, cmd_rw_q, first_q, pend_q;
  logic [ADDR_W-1:0]      ptr_q;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic sck_s, ena_s, din_s;
  logic sck_rise, sck_fall, ena_rise, ena_fall;
  logic sample, launch, word_done;
  logic [DATA_W-1:0] rx_word, tx_nxt;
  logic [ADDR_W-1:0] cmd_ptr, ptr_inc;

  // The ena flops reset high, so an ena held high through reset does not start a transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ena_sync <= '1;
      din_sync <= '0;
      sck_prev <= 1'b0;
      ena_prev <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], bus.ena};
      din_sync <= {din_sync[SYNC_STAGES-2:0], bus.din};
      sck_prev <= sck_sync[SYNC_STAGES-1];
      ena_prev <= ena_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ena_s    = ena_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign ena_rise = ena_s & ~ena_prev;
  assign ena_fall = ~ena_s & ena_prev;
  assign sample   = (cpol_q ^ cpha_q) ? sck_fall : sck_rise;
  assign launch   = (cpol_q ^ cpha_q) ? sck_rise : sck_fall;

  assign rx_word   = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], din_s} : {din_s, rx_shift_q[DATA_W-1:1]};
  // A falling ena drops ena_s in the same clk, so a word completing on that clk is discarded.
  assign word_done = (st_q != StIdle) && ena_s && sample && (cnt_q == CNT_W'(DATA_W - 1));

  assign cmd_ptr = rx_word[ADDR_W-1:0];
  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    tx_nxt = STATUS_WORD;
    case (st_q)
      StCmd:   if (!rx_word[DATA_W-1]) tx_nxt = mem[cmd_ptr];
      StRead:  tx_nxt = mem[ptr_inc];
      default: ;
    endcase
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (ena_rise) st_d = StCmd;
      StCmd:   if (word_done) st_d = rx_word[DATA_W-1] ? StWrite : StRead;
      default: ;
    endcase
    if (ena_fall) st_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= StIdle;
    else     st_q <= st_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_next_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cmd_rw_q   <= 1'b0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i + 1);
    end else begin
      rx_valid_q <= 1'b0;
      if (st_q == StIdle && ena_rise) begin
        cpol_q     <= bus.cpol;
        cpha_q     <= bus.cpha;
        cnt_q      <= '0;
        tx_shift_q <= STATUS_WORD;
        first_q    <= bus.cpha;
        pend_q     <= 1'b0;
      end else if (ena_fall) begin
        cnt_q  <= '0;
        pend_q <= 1'b0;
      end else if (st_q != StIdle && ena_s) begin
        if (sample) begin
          rx_shift_q <= rx_word;
          if (word_done) begin
            cnt_q      <= '0;
            rx_data_q  <= rx_word;
            rx_valid_q <= 1'b1;
            case (st_q)
              StCmd: begin
                cmd_rw_q <= rx_word[DATA_W-1];
                ptr_q    <= cmd_ptr;
              end
              StWrite: begin
                mem[ptr_q] <= rx_word;
                ptr_q      <= ptr_inc;
              end
              StRead:  ptr_q <= ptr_inc;
              default: ;
            endcase
            // CPHA=1 presents the new word on its first launch; CPHA=0 loads it on that launch.
            if (cpha_q) begin
              tx_shift_q <= tx_nxt;
              first_q    <= 1'b1;
            end else begin
              tx_next_q <= tx_nxt;
              pend_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else if (launch) begin
          if (pend_q) begin
            tx_shift_q <= tx_next_q;
            pend_q     <= 1'b0;
          end else if (first_q) begin
            first_q <= 1'b0;
          end else begin
            tx_shift_q <= MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                    : {1'b0, tx_shift_q[DATA_W-1:1]};
          end
        end
      end
    end
  end

  assign bus.dout     = (st_q != StIdle) ? (MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0]) : 1'b0;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (st_q != StIdle);
  assign bus.cmd_rw   = cmd_rw_q;

endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
- Parametrised, mode-configurable SPI slave memory model. Successor to the fixed mode-0, 8-bit SPI slave test model.
- Oversamples the SPI pins on the system clock, so there is one clock domain.
- Decodes a command word (read/write plus start address), then streams words to or from an internal RAM with auto-increment and wrap.
- Sits in the testbench or on the chip boundary as the target for verifying the SPI master in all four CPOL/CPHA modes.

Parameters:
- DATA_W, 8: SPI word width in bits.
- ADDR_W, 3: RAM address width; DEPTH = 2**ADDR_W. Must satisfy ADDR_W <= DATA_W-1.
- SYNC_STAGES, 2: flip-flop stages synchronising sck, ena and din. Minimum 2.
- MSB_FIRST, 1: 1 = shift MSB first; 0 = LSB first.
- STATUS_WORD, 'hA5: word returned on dout while the command word is being received, truncated to DATA_W.

Ports:
- clk, input, 1: system clock. The sck rate must be at most clk/8.
- rst, input, 1: asynchronous, active-high reset.
- cpol, input, 1: SPI clock polarity. Sampled only while ena is low.
- cpha, input, 1: SPI clock phase. Sampled only while ena is low.
- sck, input, 1: SPI clock from the master; asynchronous to clk.
- ena, input, 1: slave select, active high; asynchronous.
- din, input, 1: MOSI.
- dout, output, 1: MISO. Driven 0 when ena is low.
- rx_data, output, DATA_W: last completely received word.
- rx_valid, output, 1: one-clk pulse when rx_data updates.
- busy, output, 1: high while the FSM is not in IDLE.
- cmd_rw, output, 1: 1 = write transaction. Holds its value until the next command is decoded.

Behaviour:
- Reset (rst high, async):
  - FSM to IDLE; dout=0, rx_data=0, rx_valid=0, busy=0, cmd_rw=0.
  - Bit counter cleared; address pointer = 0.
  - mem[i] = (i+1) mod 2**DATA_W for all i.
  - A reset mid-transaction aborts it. The next transaction starts only on a fresh ena rise after rst falls.
- Synchronisation: sck, ena and din each pass through SYNC_STAGES flops. Edges are detected on the synchronised sck, giving one-clk rise/fall strobes. Response latency from a pin edge is SYNC_STAGES+1 clk.
- Edge roles:
  - The sample edge is the synced-sck rise when cpol^cpha==0, and the fall otherwise.
  - The launch edge is the opposite edge.
  - cpol and cpha are latched into internal mode registers on the ena rise.
- Shift rules:
  - rx_shift captures din on every sample edge while ena is high, into the MSB or LSB side according to MSB_FIRST.
  - The bit counter counts sample edges, 0..DATA_W-1.
  - A word completes on the sample edge where count==DATA_W-1. The counter then wraps to 0, rx_data is updated and rx_valid pulses.
  - tx_shift shifts on launch edges. dout = tx_shift[DATA_W-1] when MSB_FIRST=1, else tx_shift[0].
  - CPHA=0: tx_shift is loaded on the ena rise, so the first bit is valid before the first sample edge. Later words load on the launch edge that follows the completing sample edge.
  - CPHA=1: tx_shift is loaded on the ena rise. The first launch edge of each word presents bit 0 without shifting; a first-launch flag suppresses that shift. Later launches shift.
- FSM states: IDLE, CMD, WRITE, READ.
  - IDLE -> CMD on ena rise. tx_shift loads STATUS_WORD.
  - CMD, on word complete:
    - rw = rx[DATA_W-1] and ptr = rx[ADDR_W-1:0]; cmd_rw updates.
    - rw=1 goes to WRITE; rw=0 goes to READ.
    - The next tx word is mem[ptr] for READ and STATUS_WORD for WRITE.
  - WRITE, on each word complete: mem[ptr] <= rx word; ptr <= ptr+1 mod DEPTH.
  - READ, on each word complete: ptr <= ptr+1 mod DEPTH; the next tx word is mem[ptr+1].
- Any state -> IDLE on synced ena fall:
  - A partial word is discarded: no RAM write and no rx_valid pulse.
  - The bit counter clears and dout goes to 0.
- Wrap: ptr at DEPTH-1 increments to 0, with no error indication.
- Simultaneous events:
  - An ena fall in the same clk as a word-complete sample edge is treated as abort; the word is discarded.
  - Reset dominates everything.

Test Plan:
- Mode 0, defaults; master sends 0x02 then two dummy words -> master receives 0xA5, 0x03, 0x04. The rx_data sequence is 0x02, dummy, dummy; busy falls after ena falls.
- Mode 0; write 0x86, 0x5A, 0x3C, then read 0x07 plus two dummies -> mem[6]=0x5A and mem[7]=0x3C. The read returns 0xA5, 0x3C, 0x01, confirming wrap 7->0.
- Repeat the write/read of the previous scenario in modes 1, 2 and 3, with cpol and cpha changed only while ena is low -> identical received data in every mode.
- Abort: write 0x81, send 5 bits of 0xFF, drop ena -> mem[1] remains 0x02. No rx_valid pulse for the partial word; a following read 0x01 returns 0x02.
- Reset mid-READ: assert rst during bit 3 of the second word -> dout=0, busy=0, RAM restored to i+1. A new read 0x00 returns 0xA5, 0x01.
- MSB_FIRST=0, DATA_W=16, ADDR_W=4; read 0x0005 -> 0x00A5 then 0x0006, all bits LSB first.
